packetgen_axis_egress: RTL

//  Egress stage for packetgen: accepts wide AXIS frames from a source that cannot stall,

---
 rtl/packetgen_axis_egress.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/packetgen_axis_egress.sv
// packetgen_axis_egress
// Egress stage between packetgen and the MAC. Wide AXIS frames from a source
// that never stalls are written into a store-and-forward frame FIFO. Only whole,
// committed frames become visible to the read side. The read side splits each
// stored word into M_DATA_WIDTH segments, LSB first, and honours m_axis_tready.
// A frame that does not fit is dropped as a unit and flagged on drop_pulse.
//
// Optional feature: define PKTGEN_EGRESS_STATS_EN to build the sent/dropped
// frame counters. When it is not defined, both stat ports are tied to zero.

module packetgen_axis_egress #(
    parameter int S_DATA_WIDTH = 512,
    parameter int M_DATA_WIDTH = 64,
    parameter int DEPTH        = 64,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [S_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [S_DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                      s_axis_tvalid,
    input  logic                      s_axis_tlast,
    output logic [M_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [M_DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      m_axis_tlast,
    output logic                      drop_pulse,
    output logic [CNT_WIDTH-1:0]      stat_frames_sent,
    output logic [CNT_WIDTH-1:0]      stat_frames_dropped
);

    localparam int R    = S_DATA_WIDTH / M_DATA_WIDTH;
    localparam int SK   = S_DATA_WIDTH / 8;
    localparam int MK   = M_DATA_WIDTH / 8;
    localparam int AW   = $clog2(DEPTH);
    localparam int PW   = AW + 1;
    localparam int SEGW = (R > 1) ? $clog2(R) : 1;

    typedef enum logic [0:0] {
        IDLE,
        SEND
    } rd_state_t;

    // Frame storage: one entry per input word.
    logic [S_DATA_WIDTH-1:0] mem_data [DEPTH];
    logic [SK-1:0]           mem_keep [DEPTH];
    logic                    mem_last [DEPTH];

    // Write side state.
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] commit_ptr;
    logic          dropping;
    logic          full;
    logic          accept;

    // Read side state.
    rd_state_t               state;
    logic [PW-1:0]           rd_ptr;
    logic [AW-1:0]           rd_idx;
    logic [S_DATA_WIDTH-1:0] data_sh;
    logic [SK-1:0]           keep_sh;
    logic                    last_word;
    logic [SEGW-1:0]         seg;
    logic [SEGW-1:0]         last_seg;
    logic                    valid_q;
    logic                    tlast_q;
    logic                    avail;
    logic                    advance;
    logic                    final_seg;
    logic                    do_load;
    logic                    fetch_last;
    logic [SK-1:0]           fetch_keep;
    logic [SEGW-1:0]         fetch_seg;

    // Index of the highest output segment that carries at least one valid byte.
    // An all-zero keep still produces a single (empty) segment 0.
    function automatic logic [SEGW-1:0] last_seg_of(input logic [SK-1:0] keep);
        logic [SEGW-1:0] res;
        res = '0;
        for (int i = 0; i < R; i++) begin
            if (|keep[i*MK +: MK]) begin
                res = SEGW'(i);
            end
        end
        return res;
    endfunction

    // Occupancy is measured against the read pointer held in its register.
    // A read in the same cycle therefore frees space only from the next cycle.
    assign full   = (wr_ptr - rd_ptr) == PW'(DEPTH);
    assign accept = s_axis_tvalid && !dropping && !full;

    // The drop is flagged on the beat that closes the discarded frame. That may
    // be the overflowing beat itself.
    assign drop_pulse = !rst && s_axis_tvalid && s_axis_tlast && (dropping || full);

    // Store every accepted input beat. Storage needs no reset because the pointers
    // gate visibility.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_data[wr_ptr[AW-1:0]] <= s_axis_tdata;
            mem_keep[wr_ptr[AW-1:0]] <= s_axis_tkeep;
            mem_last[wr_ptr[AW-1:0]] <= s_axis_tlast;
        end
    end

    // Write pointer, commit point and drop state. An overflow rewinds to the last
    // committed frame and swallows the rest of the frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            commit_ptr <= '0;
            dropping   <= 1'b0;
        end else if (s_axis_tvalid) begin
            if (dropping) begin
                if (s_axis_tlast) begin
                    dropping <= 1'b0;
                end
            end else if (full) begin
                wr_ptr   <= commit_ptr;
                dropping <= !s_axis_tlast;
            end else begin
                wr_ptr <= wr_ptr + 1'b1;
                if (s_axis_tlast) begin
                    commit_ptr <= wr_ptr + 1'b1;
                end
            end
        end
    end

    assign rd_idx     = rd_ptr[AW-1:0];
    assign avail      = rd_ptr != commit_ptr;
    assign advance    = valid_q && m_axis_tready;
    assign final_seg  = seg == last_seg;
    assign fetch_last = mem_last[rd_idx];
    assign fetch_keep = fetch_last ? mem_keep[rd_idx] : '1;
    assign fetch_seg  = fetch_last ? last_seg_of(mem_keep[rd_idx]) : SEGW'(R - 1);

    // A word is fetched when the output is idle, or straight after the final
    // segment of the current word. The second case keeps back-to-back words
    // gap-free.
    assign do_load = avail && ((state == IDLE) || ((state == SEND) && advance && final_seg));

    // Output FSM: the fetched word is held in a shift register, and its low
    // segment drives the bus. Each accepted beat shifts the next segment into place.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rd_ptr    <= '0;
            data_sh   <= '0;
            keep_sh   <= '0;
            last_word <= 1'b0;
            seg       <= '0;
            last_seg  <= '0;
            valid_q   <= 1'b0;
            tlast_q   <= 1'b0;
        end else if (do_load) begin
            state     <= SEND;
            rd_ptr    <= rd_ptr + 1'b1;
            data_sh   <= mem_data[rd_idx];
            keep_sh   <= fetch_keep;
            last_word <= fetch_last;
            last_seg  <= fetch_seg;
            seg       <= '0;
            valid_q   <= 1'b1;
            tlast_q   <= fetch_last && (fetch_seg == '0);
        end else if ((state == SEND) && advance) begin
            if (!final_seg) begin
                seg     <= seg + 1'b1;
                data_sh <= data_sh >> M_DATA_WIDTH;
                keep_sh <= keep_sh >> MK;
                tlast_q <= last_word && ((seg + 1'b1) == last_seg);
            end else begin
                state   <= IDLE;
                valid_q <= 1'b0;
                tlast_q <= 1'b0;
            end
        end
    end

    assign m_axis_tdata  = data_sh[M_DATA_WIDTH-1:0];
    assign m_axis_tkeep  = keep_sh[MK-1:0];
    assign m_axis_tvalid = valid_q;
    assign m_axis_tlast  = tlast_q;

`ifdef PKTGEN_EGRESS_STATS_EN
    logic [CNT_WIDTH-1:0] sent_q;
    logic [CNT_WIDTH-1:0] dropped_q;

    // Frame counters: a frame counts as sent when its tlast beat is accepted
    // downstream. The counters wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            sent_q    <= '0;
            dropped_q <= '0;
        end else begin
            if (valid_q && m_axis_tready && tlast_q) begin
                sent_q <= sent_q + 1'b1;
            end
            if (drop_pulse) begin
                dropped_q <= dropped_q + 1'b1;
            end
        end
    end

    assign stat_frames_sent    = sent_q;
    assign stat_frames_dropped = dropped_q;
`else
    assign stat_frames_sent    = '0;
    assign stat_frames_dropped = '0;
`endif

endmodule
